icache_param: RTL
=================

Name: icache_param

Overview:
- Parametrised, set-associative, read-only instruction cache between the CPU fetch stage and the burst memory read port.
- Generalises the current fixed 8-set/4-way/32-byte I-cache in set count, associativity and line size.
- Adds true-LRU replacement with a permutation-age scheme, a latched request address, and a whole-cache invalidate for fence.i.
- Adds hit/miss performance counters.

Parameters:
- SETS, 8, number of sets; power of two, ≥2.
- WAYS, 4, associativity; power of two, ≥2.
- LINE_WORDS, 8, 32-bit words per line; power of two, ≥2.
- Derived constants: IDX_W=log2(SETS), OFF_W=log2(LINE_WORDS)+2, TAG_W=32-IDX_W-OFF_W, AGE_W=log2(WAYS).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- from_cpu_inst_req_valid  in  1  fetch request valid
- from_cpu_inst_req_addr  in  32  fetch address, 4-byte aligned
- to_cpu_inst_req_ready  out  1  cache can accept a request
- to_cpu_cache_rsp_valid  out  1  instruction valid
- to_cpu_cache_rsp_data  out  32  instruction word
- from_cpu_cache_rsp_ready  in  1  CPU accepts the response
- to_mem_rd_req_valid  out  1  line read request valid
- to_mem_rd_req_addr  out  32  line-aligned address (low OFF_W bits zero)
- from_mem_rd_req_ready  in  1  memory accepts the request
- from_mem_rd_rsp_valid  in  1  beat valid
- from_mem_rd_rsp_data  in  32  beat data
- from_mem_rd_rsp_last  in  1  final beat of the burst
- to_mem_rd_rsp_ready  out  1  cache accepts the beat
- inval_req  in  1  invalidate all lines
- inval_done  out  1  one-cycle pulse when the invalidate is complete
- hit_cnt  out  32  number of hits (wraps)
- miss_cnt  out  32  number of misses (wraps)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE; all valid bits clear; ages of way w in every set = w; counters = 0.
  - All outputs 0 except to_cpu_inst_req_ready=1 in IDLE.
- States: IDLE, LOOKUP, MISS_REQ, RECV, REFILL, RESP, INVAL.
- IDLE:
  - req_ready=1.
  - If inval_req: go to INVAL, and set req_ready=0 that cycle (invalidate has priority over a simultaneous fetch).
  - Else if req_valid: latch the address into req_addr_q, go to LOOKUP.
- LOOKUP:
  - Compare the tag of every way of set idx(req_addr_q).
  - Hit: increment hit_cnt, update ages, go to RESP.
  - Miss: increment miss_cnt, select the victim, go to MISS_REQ.
- Victim selection: lowest-index invalid way; if all ways are valid, the way whose age = WAYS-1. Victim is registered on entry to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, addr = {req_addr_q[31:OFF_W], 0}.
  - Hold valid and addr stable until from_mem_rd_req_ready, then clear the beat counter and go to RECV.
- RECV:
  - rsp_ready=1; each valid beat is written to buffer[beat_cnt], and beat_cnt increments (wraps modulo LINE_WORDS).
  - Beat with last: go to REFILL. If last arrives early, unwritten words keep stale buffer contents.
- REFILL (1 cycle):
  - Write tag and line to the victim way; set its valid bit; update ages; go to RESP.
- RESP:
  - rsp_valid=1; data = selected line word req_addr_q[OFF_W-1:2].
  - Data is held stable until from_cpu_cache_rsp_ready, then return to IDLE.
- Age update for accessed way a with old age k: age[a]=0; every way with age<k increments; others unchanged. Ages stay a permutation of 0..WAYS-1.
- INVAL:
  - Clears the valid bits of one set per cycle, index 0..SETS-1, so it takes SETS cycles.
  - Pulses inval_done on the last cycle, then returns to IDLE. Ages are untouched.
  - inval_req is sampled only in IDLE.
- Latency:
  - Hit: rsp_valid 2 cycles after the request is accepted.
  - Miss: rsp_valid 2 cycles after the last beat.
- Reset mid-operation: any state returns to IDLE next cycle. Beats still arriving are not accepted (rsp_ready=0).
- Tag and data arrays are internal reg arrays with combinational read and synchronous write.

Decomposition:
- Shared package icache_pkg holds:
  - the state encoding;
  - derived-width functions (clog2);
  - index, tag and offset slice helpers.
- One sub-module, icache_lru: per-set age storage, victim selection and age update, parametrised by SETS and WAYS.

Test Plan:
- Cold fetch at 0x00001004 → one mem req at addr 0x00001000; 8 beats D0..D7; rsp_data=D1; miss_cnt=1.
- Repeat fetch at 0x0000101C → no mem req; rsp_valid 2 cycles after accept; rsp_data=D7; hit_cnt=1.
- Fill set 0 with tags A,B,C,D, touch A, then miss on E → B evicted; a following fetch of A hits and a fetch of B misses.
- inval_req pulsed together with req_valid in IDLE → req_ready=0 that cycle; inval_done after 8 cycles; the next fetch of a previously cached line misses.
- Hold from_mem_rd_req_ready=0 for 5 cycles and rsp_ready low for 3 cycles → mem_req_valid/addr and rsp_valid/data stay constant throughout.
- rst asserted in RECV after 3 beats → IDLE next cycle; rsp_ready=0; all valid bits clear; the same address then misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the parametrised instruction cache: controller states,
// width helper and address slicing helpers used by the cache and its LRU block.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_RECV,
        S_REFILL,
        S_RESP,
        S_INVAL
    } state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return width;
    endfunction

    // Address layout is {tag, index, word offset, byte offset}
    function automatic logic [31:0] addrIndex(input logic [31:0] addr, input int offW, input int idxW);
        return (addr >> offW) & ((32'd1 << idxW) - 32'd1);
    endfunction

    function automatic logic [31:0] addrTag(input logic [31:0] addr, input int offW, input int idxW);
        return addr >> (offW + idxW);
    endfunction

    function automatic logic [31:0] addrWord(input logic [31:0] addr, input int offW);
        return (addr >> 2) & ((32'd1 << (offW - 2)) - 32'd1);
    endfunction

    function automatic logic [31:0] lineAddr(input logic [31:0] addr, input int offW);
        return addr & ~((32'd1 << offW) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-set true-LRU ages: each set holds a permutation of 0..WAYS-1 where the
// way with the largest age is the least recently used one.
module icache_lru
    import icache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 4,
    localparam int IDX_W = clog2(SETS),
    localparam int AGE_W = clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_set,
    input  logic             i_update,
    input  logic [AGE_W-1:0] i_way,
    output logic [AGE_W-1:0] o_oldest
);

    logic [AGE_W-1:0] r_age [SETS][WAYS];
    logic [AGE_W-1:0] w_oldest;

    always_comb begin
        w_oldest = '0;
        for (int way = 0; way < WAYS; way++) begin
            if (r_age[i_set][way] == AGE_W'(WAYS - 1)) begin
                w_oldest = AGE_W'(way);
            end
        end
    end

    assign o_oldest = w_oldest;

    // Accessed way becomes youngest; only ways younger than it age by one
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int way = 0; way < WAYS; way++) begin
                    r_age[s][way] <= AGE_W'(way);
                end
            end
        end else if (i_update) begin
            for (int way = 0; way < WAYS; way++) begin
                if (AGE_W'(way) == i_way) begin
                    r_age[i_set][way] <= '0;
                end else if (r_age[i_set][way] < r_age[i_set][i_way]) begin
                    r_age[i_set][way] <= r_age[i_set][way] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/icache_param.sv
// Set-associative read-only instruction cache with burst line refill,
// true-LRU replacement, whole-cache invalidate and hit/miss counters.
module icache_param
    import icache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cpu_inst_req_valid,
    input  logic [31:0] from_cpu_inst_req_addr,
    output logic        to_cpu_inst_req_ready,
    output logic        to_cpu_cache_rsp_valid,
    output logic [31:0] to_cpu_cache_rsp_data,
    input  logic        from_cpu_cache_rsp_ready,
    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready,
    input  logic        inval_req,
    output logic        inval_done,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int IDX_W  = clog2(SETS);
    localparam int WORD_W = clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int AGE_W  = clog2(WAYS);

    state_t              r_state;
    state_t              w_next_state;
    logic [31:0]         r_req_addr;
    logic [AGE_W-1:0]    r_way;
    logic [WORD_W-1:0]   r_beat_cnt;
    logic [IDX_W-1:0]    r_inval_idx;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [31:0]         r_data  [SETS][WAYS][LINE_WORDS];
    logic [31:0]         r_buf   [LINE_WORDS];

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WORD_W-1:0]   w_word;
    logic                w_hit;
    logic [AGE_W-1:0]    w_hit_way;
    logic                w_free;
    logic [AGE_W-1:0]    w_free_way;
    logic [AGE_W-1:0]    w_lru_way;
    logic [AGE_W-1:0]    w_victim;
    logic                w_lru_update;
    logic [AGE_W-1:0]    w_lru_way_in;

    assign w_idx  = IDX_W'(addrIndex(r_req_addr, OFF_W, IDX_W));
    assign w_tag  = TAG_W'(addrTag(r_req_addr, OFF_W, IDX_W));
    assign w_word = WORD_W'(addrWord(r_req_addr, OFF_W));

    // Descending scan so the lowest-index match or free way wins
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_free     = 1'b0;
        w_free_way = '0;
        for (int way = WAYS - 1; way >= 0; way--) begin
            if (r_valid[w_idx][way] && (r_tag[w_idx][way] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AGE_W'(way);
            end
            if (!r_valid[w_idx][way]) begin
                w_free     = 1'b1;
                w_free_way = AGE_W'(way);
            end
        end
    end

    assign w_victim     = w_free ? w_free_way : w_lru_way;
    assign w_lru_update = ((r_state == S_LOOKUP) && w_hit) || (r_state == S_REFILL);
    assign w_lru_way_in = (r_state == S_LOOKUP) ? w_hit_way : r_way;

    icache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk      (clk),
        .rst      (rst),
        .i_set    (w_idx),
        .i_update (w_lru_update),
        .i_way    (w_lru_way_in),
        .o_oldest (w_lru_way)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_addr  <= '0;
            r_way       <= '0;
            r_beat_cnt  <= '0;
            r_inval_idx <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    r_inval_idx <= '0;
                    if (!inval_req && from_cpu_inst_req_valid) begin
                        r_req_addr <= from_cpu_inst_req_addr;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_hit_cnt <= r_hit_cnt + 32'd1;
                        r_way     <= w_hit_way;
                    end else begin
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_way      <= w_victim;
                    end
                end
                S_MISS_REQ: begin
                    if (from_mem_rd_req_ready) begin
                        r_beat_cnt <= '0;
                    end
                end
                S_RECV: begin
                    if (from_mem_rd_rsp_valid) begin
                        r_beat_cnt <= r_beat_cnt + WORD_W'(1);
                    end
                end
                S_REFILL: begin
                    r_valid[w_idx][r_way] <= 1'b1;
                end
                S_INVAL: begin
                    r_valid[r_inval_idx] <= '0;
                    r_inval_idx          <= r_inval_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; validity alone decides whether they are used
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_RECV) && from_mem_rd_rsp_valid) begin
            r_buf[r_beat_cnt] <= from_mem_rd_rsp_data;
        end
        if (!rst && (r_state == S_REFILL)) begin
            r_tag[w_idx][r_way] <= w_tag;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_data[w_idx][r_way][i] <= r_buf[i];
            end
        end
    end

    always_comb begin
        w_next_state            = r_state;
        to_cpu_inst_req_ready   = 1'b0;
        to_cpu_cache_rsp_valid  = 1'b0;
        to_cpu_cache_rsp_data   = '0;
        to_mem_rd_req_valid     = 1'b0;
        to_mem_rd_req_addr      = '0;
        to_mem_rd_rsp_ready     = 1'b0;
        inval_done              = 1'b0;
        case (r_state)
            S_IDLE: begin
                to_cpu_inst_req_ready = !inval_req;
                if (inval_req) begin
                    w_next_state = S_INVAL;
                end else if (from_cpu_inst_req_valid) begin
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_next_state = w_hit ? S_RESP : S_MISS_REQ;
            end
            S_MISS_REQ: begin
                to_mem_rd_req_valid = 1'b1;
                to_mem_rd_req_addr  = lineAddr(r_req_addr, OFF_W);
                if (from_mem_rd_req_ready) begin
                    w_next_state = S_RECV;
                end
            end
            S_RECV: begin
                to_mem_rd_rsp_ready = 1'b1;
                if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) begin
                    w_next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                to_cpu_cache_rsp_valid = 1'b1;
                to_cpu_cache_rsp_data  = r_data[w_idx][r_way][w_word];
                if (from_cpu_cache_rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_INVAL: begin
                if (r_inval_idx == IDX_W'(SETS - 1)) begin
                    inval_done   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule
